hms_counter: RTL and testbench
==============================

HMS_COUNTER -- requirements
Module: hms_counter

Interface
REQ-001 SHALL have parameter SEC_MOD, default 60, seconds modulus.
REQ-002 SHALL have parameter MIN_MOD, default 60, minutes modulus.
REQ-003 SHALL have parameter HR_MOD, default 24, hours modulus (12 and 24 both legal).
REQ-004 SHALL have parameter W, default 7, field width; every *_MOD must be <= 2**W.
REQ-005 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port tick  in  1  one-cycle pulse, advance time by one second.
REQ-008 SHALL have port load  in  1  load all three fields from load_* inputs.
REQ-009 SHALL have ports load_sec / load_min / load_hr  in  W  load values.
REQ-010 SHALL have port adj_sel  in  2  field select: 0 sec, 1 min, 2 hr, 3 none.
REQ-011 SHALL have ports adj_up / adj_dn  in  1  step the selected field by +1 or -1.
REQ-012 SHALL have ports sec / min / hr  out  W  current time, registered.
REQ-013 SHALL have port day_wrap  out  1  one-cycle pulse on full wrap to 0:0:0.
REQ-014 SHALL have port load_err  out  1  one-cycle pulse on a rejected load.

Function
REQ-015 SHALL apply priority rst > load > adjust > tick each cycle; a lower-priority request in the same cycle is dropped.
REQ-016 SHALL, on tick, increment sec; sec wrapping SEC_MOD-1 -> 0 SHALL increment min in the same edge; min wrap SHALL likewise increment hr.
REQ-017 SHALL update outputs on the clk edge that samples tick, making them visible one cycle after tick is asserted.
REQ-018 SHALL pulse day_wrap for exactly one cycle when a tick moves HR_MOD-1:MIN_MOD-1:SEC_MOD-1 to 0:0:0; adjust and load wraps SHALL NOT pulse it.
REQ-019 SHALL, on load with every value below its modulus, write all three fields together.
REQ-020 SHALL, on load with any value >= its modulus, leave all fields unchanged and pulse load_err for one cycle.
REQ-021 SHALL, on adjust, step only the selected field modulo its own modulus (up from MOD-1 -> 0, down from 0 -> MOD-1), with no carry or borrow into other fields.
REQ-022 SHALL treat adj_up and adj_dn asserted together, or adj_sel=3, as no adjust; such a cycle SHALL NOT block a tick.
REQ-023 SHALL have no tick prescaler; tick frequency is the caller's responsibility.

Reset
REQ-024 SHALL, on rst, set sec=0, min=0, hr=0, day_wrap=0, load_err=0 at the next edge, regardless of other inputs, including mid-carry.
REQ-025 SHALL resume counting on the first tick after rst deasserts.

Structure
REQ-026 SHALL take default moduli, the adj_sel encoding (ADJ_SEC, ADJ_MIN, ADJ_HR, ADJ_NONE) and W from shared package clock_pkg.
REQ-027 SHALL instantiate three copies of sub-module mod_counter (params MOD, W; inputs inc, dec, ld, ld_val; outputs val and a wrap flag), with carry chaining in hms_counter.
REQ-028 SHALL contain no latches, no combinational outputs, and no second clock domain.

Verification
REQ-029 SHALL cover: 59 ticks from reset -> sec=59, min=0; 60th tick -> sec=0, min=1.
REQ-030 SHALL cover: load 23:59:59, then one tick -> 0:0:0 with day_wrap high exactly one cycle.
REQ-031 SHALL cover: load 0:60:0 (MIN_MOD=60) -> fields unchanged, load_err one-cycle pulse.
REQ-032 SHALL cover: sec=0, adj_sel=0, adj_dn -> sec=59, min unchanged; adj_sel=2, adj_up at hr=23 -> hr=0, no day_wrap.
REQ-033 SHALL cover: tick with load in the same cycle -> load value wins, tick lost; tick with adj_up and adj_dn both set -> tick applied.
REQ-034 SHALL cover: HR_MOD=12 instance, 11:59:59 plus tick -> 0:0:0 with day_wrap; rst mid-sequence -> all outputs zero next cycle.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared constants for the hours/minutes/seconds counter: default moduli,
// field width and the encoding of the adjust field select.
package clock_pkg;

  // Default field width and moduli for a 24-hour clock.
  localparam int W_DEF       = 7;
  localparam int SEC_MOD_DEF = 60;
  localparam int MIN_MOD_DEF = 60;
  localparam int HR_MOD_DEF  = 24;

  // Field select for the manual adjust inputs.
  typedef enum logic [1:0] {
    ADJ_SEC  = 2'd0,
    ADJ_MIN  = 2'd1,
    ADJ_HR   = 2'd2,
    ADJ_NONE = 2'd3
  } adj_sel_e;

  // True when a W-bit value is a legal field value for the given modulus.
  // The compare is done one bit wider so a modulus of exactly 2**W works.
  function automatic logic below_mod(input logic [31:0] value, input int modulus);
    return value < 32'(modulus);
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Single modulo-MOD field counter with load, increment and decrement.
// The wrap output is combinational: it flags that the increment requested
// this cycle will roll the field from MOD-1 back to 0, so the parent can
// carry into the next field on the same clock edge.
module mod_counter
  import clock_pkg::*;
#(
  parameter int MOD = SEC_MOD_DEF,
  parameter int W   = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  output logic [W-1:0] val,
  output logic         wrap
);

  localparam logic [W-1:0] MAXV = W'(MOD - 1);

  logic [W-1:0] val_q;
  logic [W-1:0] val_d;
  logic         at_max;
  logic         at_zero;

  assign at_max  = (val_q == MAXV);
  assign at_zero = (val_q == '0);

  // Next value: load wins, then increment, then decrement; both wrap within MOD.
  always_comb begin
    val_d = val_q;
    if (ld) begin
      val_d = ld_val;
    end else if (inc) begin
      val_d = at_max ? '0 : val_q + W'(1);
    end else if (dec) begin
      val_d = at_zero ? MAXV : val_q - W'(1);
    end
  end

  // Field register with synchronous reset to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      val_q <= '0;
    end else begin
      val_q <= val_d;
    end
  end

  assign val  = val_q;
  assign wrap = inc && !ld && at_max;

endmodule

// File: rtl/hms_counter.sv
// Hours:minutes:seconds time-of-day counter. Each cycle resolves one of
// load, adjust or tick (in that priority, reset above all); the others
// are dropped. Tick carries seconds into minutes into hours on one edge,
// and only a tick that rolls the whole day over raises day_wrap.
module hms_counter
  import clock_pkg::*;
#(
  parameter int SEC_MOD = SEC_MOD_DEF,
  parameter int MIN_MOD = MIN_MOD_DEF,
  parameter int HR_MOD  = HR_MOD_DEF,
  parameter int W       = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic         load,
  input  logic [W-1:0] load_sec,
  input  logic [W-1:0] load_min,
  input  logic [W-1:0] load_hr,
  input  logic [1:0]   adj_sel,
  input  logic         adj_up,
  input  logic         adj_dn,
  output logic [W-1:0] sec,
  output logic [W-1:0] min,
  output logic [W-1:0] hr,
  output logic         day_wrap,
  output logic         load_err
);

  adj_sel_e sel;
  logic     load_ok;
  logic     adj_act;

  logic sec_inc, sec_dec, min_inc, min_dec, hr_inc, hr_dec, fld_ld;
  logic sec_wrap, min_wrap, hr_wrap;

  logic day_wrap_q, day_wrap_d;
  logic load_err_q, load_err_d;

  assign sel = adj_sel_e'(adj_sel);

  // A load is only accepted when every field value is inside its modulus.
  assign load_ok = below_mod(32'(load_sec), SEC_MOD) &&
                   below_mod(32'(load_min), MIN_MOD) &&
                   below_mod(32'(load_hr),  HR_MOD);

  // Conflicting up/down or the "none" select is not an adjust at all,
  // so it must not steal the cycle from a tick.
  assign adj_act = (adj_up ^ adj_dn) && (sel != ADJ_NONE);

  // Request arbitration and carry chaining for the three field counters.
  always_comb begin
    fld_ld     = 1'b0;
    sec_inc    = 1'b0;
    sec_dec    = 1'b0;
    min_inc    = 1'b0;
    min_dec    = 1'b0;
    hr_inc     = 1'b0;
    hr_dec     = 1'b0;
    day_wrap_d = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      if (load_ok) begin
        fld_ld = 1'b1;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (adj_act) begin
      unique case (sel)
        ADJ_SEC: begin
          sec_inc = adj_up;
          sec_dec = adj_dn;
        end
        ADJ_MIN: begin
          min_inc = adj_up;
          min_dec = adj_dn;
        end
        ADJ_HR: begin
          hr_inc = adj_up;
          hr_dec = adj_dn;
        end
        default: ;
      endcase
    end else if (tick) begin
      sec_inc    = 1'b1;
      min_inc    = sec_wrap;
      hr_inc     = min_wrap;
      day_wrap_d = hr_wrap;
    end
  end

  mod_counter #(.MOD(SEC_MOD), .W(W)) u_sec (
    .clk    (clk),
    .rst    (rst),
    .inc    (sec_inc),
    .dec    (sec_dec),
    .ld     (fld_ld),
    .ld_val (load_sec),
    .val    (sec),
    .wrap   (sec_wrap)
  );

  mod_counter #(.MOD(MIN_MOD), .W(W)) u_min (
    .clk    (clk),
    .rst    (rst),
    .inc    (min_inc),
    .dec    (min_dec),
    .ld     (fld_ld),
    .ld_val (load_min),
    .val    (min),
    .wrap   (min_wrap)
  );

  mod_counter #(.MOD(HR_MOD), .W(W)) u_hr (
    .clk    (clk),
    .rst    (rst),
    .inc    (hr_inc),
    .dec    (hr_dec),
    .ld     (fld_ld),
    .ld_val (load_hr),
    .val    (hr),
    .wrap   (hr_wrap)
  );

  // Registered one-cycle status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      day_wrap_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      day_wrap_q <= day_wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign day_wrap = day_wrap_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_hms_counter.sv
// Directed self-checking bench for hms_counter: a default 24-hour instance
// and a 12-hour instance share the same stimulus.
module tb_hms_counter;

  localparam int W = 7;

  logic         clk = 1'b0;
  logic         rst, tick, load, adj_up, adj_dn;
  logic [W-1:0] load_sec, load_min, load_hr;
  logic [1:0]   adj_sel;

  logic [W-1:0] sec24, min24, hr24, sec12, min12, hr12;
  logic         dw24, le24, dw12, le12;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hms_counter dut24 (
    .clk(clk), .rst(rst), .tick(tick), .load(load),
    .load_sec(load_sec), .load_min(load_min), .load_hr(load_hr),
    .adj_sel(adj_sel), .adj_up(adj_up), .adj_dn(adj_dn),
    .sec(sec24), .min(min24), .hr(hr24), .day_wrap(dw24), .load_err(le24)
  );

  hms_counter #(.HR_MOD(12)) dut12 (
    .clk(clk), .rst(rst), .tick(tick), .load(load),
    .load_sec(load_sec), .load_min(load_min), .load_hr(load_hr),
    .adj_sel(adj_sel), .adj_up(adj_up), .adj_dn(adj_dn),
    .sec(sec12), .min(min12), .hr(hr12), .day_wrap(dw12), .load_err(le12)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic chk24(input string tag, input int h, input int m, input int s,
                       input logic dw, input logic le);
    chk({tag, ".hr"},  32'(hr24),  32'(h));
    chk({tag, ".min"}, 32'(min24), 32'(m));
    chk({tag, ".sec"}, 32'(sec24), 32'(s));
    chk({tag, ".day_wrap"}, 32'(dw24), 32'(dw));
    chk({tag, ".load_err"}, 32'(le24), 32'(le));
  endtask

  task automatic chk12(input string tag, input int h, input int m, input int s,
                       input logic dw, input logic le);
    chk({tag, ".hr12"},  32'(hr12),  32'(h));
    chk({tag, ".min12"}, 32'(min12), 32'(m));
    chk({tag, ".sec12"}, 32'(sec12), 32'(s));
    chk({tag, ".day_wrap12"}, 32'(dw12), 32'(dw));
    chk({tag, ".load_err12"}, 32'(le12), 32'(le));
  endtask

  // Advance one clock and settle just after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; tick = 0; load = 0; adj_up = 0; adj_dn = 0; adj_sel = 2'd3;
    load_sec = '0; load_min = '0; load_hr = '0;
  endtask

  task automatic do_load(input int h, input int m, input int s);
    load = 1; load_hr = W'(h); load_min = W'(m); load_sec = W'(s);
    cyc();
    idle();
  endtask

  task automatic do_tick();
    tick = 1;
    cyc();
    tick = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst = 1;
    tick = 1; load = 1; load_hr = 7'd3;
    cyc();
    cyc();
    idle();
    chk24("reset", 0, 0, 0, 0, 0);
    chk12("reset", 0, 0, 0, 0, 0);

    // 59 ticks from reset, then the 60th carries into minutes.
    for (int i = 0; i < 59; i++) do_tick();
    chk24("tick59", 0, 0, 59, 0, 0);
    do_tick();
    chk24("tick60", 0, 1, 0, 0, 0);
    cyc();
    chk24("idle_hold", 0, 1, 0, 0, 0);

    // Full day rollover.
    do_load(23, 59, 59);
    chk24("load235959", 23, 59, 59, 0, 0);
    do_tick();
    chk24("daywrap", 0, 0, 0, 1, 0);
    cyc();
    chk24("daywrap_end", 0, 0, 0, 0, 0);

    // Rejected load keeps the old time.
    do_load(10, 20, 30);
    chk24("load102030", 10, 20, 30, 0, 0);
    do_load(0, 60, 0);
    chk24("load_bad", 10, 20, 30, 0, 1);
    cyc();
    chk24("load_bad_end", 10, 20, 30, 0, 0);
    do_load(24, 0, 0);
    chk24("load_bad_hr", 10, 20, 30, 0, 1);

    // Adjust seconds down from 0: no borrow.
    do_load(5, 7, 0);
    adj_sel = 2'd0; adj_dn = 1;
    cyc();
    idle();
    chk24("adj_sec_dn", 5, 7, 59, 0, 0);

    // Adjust minutes up from 59: no carry.
    do_load(5, 59, 10);
    adj_sel = 2'd1; adj_up = 1;
    cyc();
    idle();
    chk24("adj_min_up", 5, 0, 10, 0, 0);

    // Adjust hours up from 23: wraps, no day_wrap.
    do_load(23, 7, 59);
    adj_sel = 2'd2; adj_up = 1;
    cyc();
    idle();
    chk24("adj_hr_up", 0, 7, 59, 0, 0);
    adj_sel = 2'd2; adj_dn = 1;
    cyc();
    idle();
    chk24("adj_hr_dn", 23, 7, 59, 0, 0);

    // Load beats tick in the same cycle.
    tick = 1;
    do_load(1, 2, 3);
    chk24("load_vs_tick", 1, 2, 3, 0, 0);
    // Conflicting up/down does not block a tick.
    tick = 1; adj_sel = 2'd0; adj_up = 1; adj_dn = 1;
    cyc();
    idle();
    chk24("tick_updn", 1, 2, 4, 0, 0);
    // Select "none" does not block a tick.
    tick = 1; adj_sel = 2'd3; adj_up = 1;
    cyc();
    idle();
    chk24("tick_selnone", 1, 2, 5, 0, 0);
    // A real adjust drops the tick.
    tick = 1; adj_sel = 2'd1; adj_up = 1;
    cyc();
    idle();
    chk24("adj_vs_tick", 1, 3, 5, 0, 0);

    // 12-hour rollover; the 24-hour instance just moves to noon.
    do_load(11, 59, 59);
    chk12("load115959", 11, 59, 59, 0, 0);
    do_tick();
    chk12("daywrap12", 0, 0, 0, 1, 0);
    chk24("noon24", 12, 0, 0, 0, 0);
    cyc();
    chk12("daywrap12_end", 0, 0, 0, 0, 0);

    // Reset in the middle of a full carry.
    do_load(23, 59, 59);
    rst = 1; tick = 1;
    cyc();
    idle();
    chk24("rst_mid", 0, 0, 0, 0, 0);
    chk12("rst_mid", 0, 0, 0, 0, 0);
    do_tick();
    chk24("resume", 0, 0, 1, 0, 0);

    // Reset clears a pending load_err pulse.
    load = 1; load_sec = 7'd99;
    cyc();
    chk24("err_before_rst", 0, 0, 1, 0, 1);
    idle();
    rst = 1;
    cyc();
    idle();
    chk24("rst_err", 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
